// File: rtl/huff_len_ctrl.sv
// Huffman code-length sequencer for 8 symbols; drives an external 8-entry descending sort network.
// Build option: define HUFF_SAT_EN to saturate merge sums and flag them on out_sat (otherwise sums wrap).
module huff_len_ctrl #(
  parameter int WW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [WW-1:0]   in_weight,
  output logic [31:0]     sort_char,
  output logic [8*WW-1:0] sort_weight,
  input  logic [31:0]     sort_res,
  output logic            out_valid,
  output logic [2:0]      out_len,
  output logic            out_sat
);

  typedef enum logic [2:0] {IDLE, LOAD, SORT, MERGE, OUT} state_t;

  localparam logic [3:0]    PAD_ID = 4'd15;
  localparam logic [WW-1:0] PAD_W  = '1;

  state_t        state;
  logic [WW-1:0] node_w    [15];
  logic [7:0]    node_mask [15];
  logic [3:0]    list      [8];
  logic [2:0]    len       [8];
  logic [2:0]    cnt;
  logic [2:0]    round;

  // ID-indexed views with the PAD entry appended, so any 4-bit ID can be looked up directly.
  logic [WW-1:0] w_by_id    [16];
  logic [7:0]    mask_by_id [16];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      w_by_id[i]    = node_w[i];
      mask_by_id[i] = node_mask[i];
    end
    w_by_id[15]    = PAD_W;
    mask_by_id[15] = '0;
  end

  always_comb begin
    sort_char   = '0;
    sort_weight = '0;
    for (int i = 0; i < 8; i++) begin
      sort_char[31-4*i -: 4]           = list[i];
      sort_weight[8*WW-1-WW*i -: WW]   = w_by_id[list[i]];
    end
  end

  logic [3:0]    a_id, b_id, new_id;
  logic [7:0]    new_mask;
  logic [WW-1:0] new_w;

  assign a_id     = list[6];
  assign b_id     = list[7];
  assign new_id   = 4'd8 + {1'b0, round};
  assign new_mask = mask_by_id[a_id] | mask_by_id[b_id];

`ifdef HUFF_SAT_EN
  logic [WW:0] sum_full;
  logic        sum_ovf;
  logic        sat_q;

  assign sum_full = {1'b0, w_by_id[a_id]} + {1'b0, w_by_id[b_id]};
  assign sum_ovf  = sum_full[WW];
  assign new_w    = sum_ovf ? PAD_W : sum_full[WW-1:0];

  // Sticky for the whole operation; cleared on the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (state == MERGE && sum_ovf) begin
      sat_q <= 1'b1;
    end else if (state == OUT && cnt == 3'd7) begin
      sat_q <= 1'b0;
    end
  end

  assign out_sat = sat_q;
`else
  assign new_w   = w_by_id[a_id] + w_by_id[b_id];
  assign out_sat = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      round     <= '0;
      out_valid <= 1'b0;
      out_len   <= '0;
      // NOTE: these small register arrays are reset explicitly; they are flops, not a RAM macro.
      for (int i = 0; i < 15; i++) begin
        node_w[i]    <= '0;
        node_mask[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        list[i] <= '0;
        len[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (in_valid) begin
            node_w[cnt]    <= in_weight;
            node_mask[cnt] <= 8'b1 << cnt;
            list[cnt]      <= {1'b0, cnt};
            cnt            <= cnt + 3'd1;
            state          <= (cnt == 3'd7) ? SORT : LOAD;
          end
        end
        SORT: begin
          for (int i = 0; i < 8; i++) list[i] <= sort_res[31-4*i -: 4];
          state <= MERGE;
        end
        MERGE: begin
          node_w[new_id]    <= new_w;
          node_mask[new_id] <= new_mask;
          for (int k = 0; k < 8; k++) begin
            if (new_mask[k]) len[k] <= len[k] + 3'd1;
          end
          list[6] <= PAD_ID;
          list[7] <= new_id;
          round   <= round + 3'd1;
          if (round == 3'd6) begin
            // The last merge covers every symbol, so symbol 0's final length is known now.
            state     <= OUT;
            out_valid <= 1'b1;
            out_len   <= len[0] + {2'b0, new_mask[0]};
            cnt       <= '0;
          end else begin
            state <= SORT;
          end
        end
        OUT: begin
          if (cnt == 3'd7) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_len   <= '0;
            cnt       <= '0;
            round     <= '0;
            for (int i = 0; i < 15; i++) begin
              node_w[i]    <= '0;
              node_mask[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
              list[i] <= '0;
              len[i]  <= '0;
            end
          end else begin
            cnt     <= cnt + 3'd1;
            out_len <= len[cnt + 3'd1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_len_ctrl.sv
// Self-checking bench for huff_len_ctrl: models the external sort network and scoreboards code lengths.
module tb_huff_len_ctrl;

  localparam int WW   = 5;
  localparam int MAXW = (1 << WW) - 1;

  typedef logic [WW-1:0] wvec_t [8];
  typedef logic [2:0]    lens_t [8];

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [WW-1:0]   in_weight = '0;
  logic [31:0]     sort_char;
  logic [8*WW-1:0] sort_weight;
  logic [31:0]     sort_res;
  logic            out_valid;
  logic [2:0]      out_len;
  logic            out_sat;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_len_q [$];
  logic       exp_sat_q [$];

  always #5 clk = ~clk;

  huff_len_ctrl #(.WW(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_weight  (in_weight),
    .sort_char  (sort_char),
    .sort_weight(sort_weight),
    .sort_res   (sort_res),
    .out_valid  (out_valid),
    .out_len    (out_len),
    .out_sat    (out_sat)
  );

  // External sort network: descending weight, ties larger ID first, identical entries keep input order.
  function automatic logic [31:0] sort_net(input logic [31:0] ch, input logic [8*WW-1:0] wt);
    logic [3:0]    id [8];
    logic [WW-1:0] w  [8];
    logic [31:0]   res;
    int            rank;
    for (int i = 0; i < 8; i++) begin
      id[i] = ch[31-4*i -: 4];
      w[i]  = wt[8*WW-1-WW*i -: WW];
    end
    res = '0;
    for (int i = 0; i < 8; i++) begin
      rank = 0;
      for (int j = 0; j < 8; j++) begin
        if (j != i && (w[j] > w[i] || (w[j] == w[i] &&
            (id[j] > id[i] || (id[j] == id[i] && j < i)))))
          rank++;
      end
      res[31-4*rank -: 4] = id[i];
    end
    return res;
  endfunction

  assign sort_res = sort_net(sort_char, sort_weight);

  // Reference: repeatedly merge the two lightest live nodes (ties: lower ID counts as lighter).
  function automatic void model_huff(input wvec_t w, output lens_t len, output logic sat);
    int         nw  [15];
    logic [7:0] nm  [15];
    bit         act [15];
    int         a, b, s;
    sat = 1'b0;
    for (int i = 0; i < 15; i++) begin
      nw[i] = 0; nm[i] = '0; act[i] = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      len[k] = '0;
      nw[k]  = int'(w[k]);
      nm[k]  = 8'(1 << k);
      act[k] = 1'b1;
    end
    for (int r = 0; r < 7; r++) begin
      a = -1; b = -1;
      for (int i = 0; i < 15; i++) begin
        if (act[i]) begin
          if (a < 0 || nw[i] < nw[a]) begin
            b = a; a = i;
          end else if (b < 0 || nw[i] < nw[b]) begin
            b = i;
          end
        end
      end
      s = nw[a] + nw[b];
      if (s > MAXW) begin
`ifdef HUFF_SAT_EN
        sat = 1'b1;
        s   = MAXW;
`else
        s   = s % (MAXW + 1);
`endif
      end
      nw[8+r]  = s;
      nm[8+r]  = nm[a] | nm[b];
      act[a]   = 1'b0;
      act[b]   = 1'b0;
      act[8+r] = 1'b1;
      for (int k = 0; k < 8; k++) if (nm[8+r][k]) len[k] = len[k] + 3'd1;
    end
  endfunction

  // Drives one operation starting at a negedge and checks it; returns at the negedge after out_valid falls.
  task automatic run_op(input string name, input wvec_t w, input lens_t exp_len,
                        input logic exp_sat, input bit disturb);
    int         lat;
    logic [2:0] e_len;
    logic       e_sat;
    for (int k = 0; k < 8; k++) begin
      exp_len_q.push_back(exp_len[k]);
      exp_sat_q.push_back(exp_sat);
    end
    for (int k = 0; k < 8; k++) begin
      in_valid  = 1'b1;
      in_weight = w[k];
      @(negedge clk);
    end
    in_valid  = disturb;
    in_weight = WW'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      in_weight = WW'($urandom);
    end
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 15", name, lat);
    end
    for (int i = 0; i < 8; i++) begin
      e_len = exp_len_q.pop_front();
      e_sat = exp_sat_q.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s out_valid[%0d]: got %b expected 1", name, i, out_valid);
      end
      checks++;
      if (out_len !== e_len) begin
        errors++;
        $display("FAIL %s out_len[%0d]: got %0d expected %0d", name, i, out_len, e_len);
      end
      checks++;
      if (out_sat !== e_sat) begin
        errors++;
        $display("FAIL %s out_sat[%0d]: got %b expected %b", name, i, out_sat, e_sat);
      end
      in_valid  = disturb;
      in_weight = WW'($urandom);
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s out_valid_fall: got %b expected 0", name, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_len !== 3'd0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b len=%0d sat=%b expected 0/0/0", out_valid, out_len, out_sat);
    end
    checks++;
    if (sort_char !== 32'h0 || sort_weight !== '0) begin
      errors++;
      $display("FAIL reset_sort_bus: got char=%h weight=%h expected 0/0", sort_char, sort_weight);
    end
  endtask

  task automatic test_uniform();
    wvec_t w   = '{default: WW'(1)};
    lens_t exp = '{default: 3'd3};
    run_op("uniform", w, exp, 1'b0, 1'b0);
  endtask

  task automatic test_skewed(input string name, input bit disturb);
    wvec_t w   = '{WW'(8), WW'(4), WW'(2), WW'(1), WW'(1), WW'(0), WW'(0), WW'(0)};
    lens_t exp = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd7, 3'd7, 3'd6};
    run_op(name, w, exp, 1'b0, disturb);
  endtask

  task automatic test_saturation();
    wvec_t w = '{WW'(20), WW'(20), WW'(0), WW'(0), WW'(0), WW'(0), WW'(0), WW'(0)};
    lens_t exp;
    logic  msat;
    logic  exp_sat;
    model_huff(w, exp, msat);
`ifdef HUFF_SAT_EN
    exp_sat = 1'b1;
`else
    exp_sat = 1'b0;
`endif
    run_op("saturation", w, exp, exp_sat, 1'b0);
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid  = 1'b1;
      in_weight = WW'(1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sort_char !== 32'h0) begin
      errors++;
      $display("FAIL abort_async_clear: got valid=%b char=%h expected 0/0", out_valid, sort_char);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_output: got out_valid seen=%b expected 0", seen);
    end
    test_uniform();
  endtask

  task automatic test_back_to_back();
    wvec_t w1, w2;
    lens_t e1, e2;
    logic  s1, s2;
    for (int k = 0; k < 8; k++) begin
      w1[k] = WW'($urandom_range(0, MAXW));
      w2[k] = WW'($urandom_range(0, 6));
    end
    model_huff(w1, e1, s1);
    model_huff(w2, e2, s2);
    run_op("b2b_first", w1, e1, s1, 1'b0);
    run_op("b2b_second", w2, e2, s2, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_uniform();
    test_skewed("skewed", 1'b0);
    test_saturation();
    test_reset_abort();
    test_skewed("ignore_in_valid", 1'b1);
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
